// File: rtl/reg_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : reg_ctrl_pkg
// Description : Shared encodings for the register-file command sequencer:
//               operation codes, FSM state codes and register index constants.
// Revision    : 1.0  initial release
//==============================================================================
package reg_ctrl_pkg;

   // Command operation encodings (match the 2-bit cmd_op field)
   typedef enum logic [1:0] {
      OP_MOV = 2'b00,
      OP_ADD = 2'b01,
      OP_SUB = 2'b10,
      OP_LDI = 2'b11
   } op_t;

   // Sequencer states; one command walks through all four in order
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WRITE = 2'd3
   } state_t;

   // Register file index of each read port r1..r4
   localparam logic [1:0] R1_IDX = 2'd0;
   localparam logic [1:0] R2_IDX = 2'd1;
   localparam logic [1:0] R3_IDX = 2'd2;
   localparam logic [1:0] R4_IDX = 2'd3;

endpackage : reg_ctrl_pkg
`default_nettype wire

// File: rtl/reg_ctrl_seq_if.sv
`default_nettype none
//==============================================================================
// Module      : reg_ctrl_seq_if
// Description : Command handshake bundle between the stimulus/control logic
//               (master) and the register-file sequencer (slave).
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  sequencer can accept a command
//   cmd_op     master->slave  operation (MOV/ADD/SUB/LDI)
//   cmd_dst    master->slave  destination register index
//   cmd_srca   master->slave  operand A register index
//   cmd_srcb   master->slave  operand B register index
//   cmd_imm    master->slave  immediate for LDI
// Revision    : 1.0  initial release
//==============================================================================
interface reg_ctrl_seq_if #(
   parameter int N = 16
) ();

   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [1:0]    cmd_dst;
   logic [1:0]    cmd_srca;
   logic [1:0]    cmd_srcb;
   logic [N-1:0]  cmd_imm;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_dst,
      output cmd_srca,
      output cmd_srcb,
      output cmd_imm,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_dst,
      input  cmd_srca,
      input  cmd_srcb,
      input  cmd_imm,
      output cmd_ready
   );

endinterface : reg_ctrl_seq_if
`default_nettype wire

// File: rtl/reg_ctrl_alu.sv
`default_nettype none
//==============================================================================
// Module      : reg_ctrl_alu
// Description : Combinational datapath of the sequencer.
//               MOV -> a, ADD -> a+b, SUB -> a-b, LDI -> imm.
//               carry is the carry out of ADD or the borrow (a<b) of SUB;
//               it is 0 for MOV/LDI (the caller ignores it for those ops).
//               Optional macro REG_CTRL_SAT_EN: ADD clamps to all-ones on
//               carry and SUB clamps to zero on borrow; carry still reports.
// Ports       : op, a, b, imm in; result, carry out
// Revision    : 1.0  initial release
//==============================================================================
module reg_ctrl_alu
   import reg_ctrl_pkg::*;
#(
   parameter int N = 16
) (
   input  op_t          op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [N-1:0] imm,
   output logic [N-1:0] result,
   output logic         carry
);

   // One extra bit captures carry (add) or borrow (subtract)
   logic [N:0] w_sum;
   logic [N:0] w_diff;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};

   always_comb begin
      result = a;
      carry  = 1'b0;
      case (op)
         OP_MOV: begin
            result = a;
         end
         OP_ADD: begin
            carry = w_sum[N];
`ifdef REG_CTRL_SAT_EN
            result = w_sum[N] ? {N{1'b1}} : w_sum[N-1:0];
`else
            result = w_sum[N-1:0];
`endif
         end
         OP_SUB: begin
            // Top bit of the widened difference is set exactly when a < b
            carry = w_diff[N];
`ifdef REG_CTRL_SAT_EN
            result = w_diff[N] ? {N{1'b0}} : w_diff[N-1:0];
`else
            result = w_diff[N-1:0];
`endif
         end
         OP_LDI: begin
            result = imm;
         end
         default: begin
            result = a;
         end
      endcase
   end

endmodule : reg_ctrl_alu
`default_nettype wire

// File: rtl/reg_ctrl_seq.sv
`default_nettype none
//==============================================================================
// Module      : reg_ctrl_seq
// Description : Command sequencer driving the write side of a 4-entry
//               register file. Each accepted command runs
//               IDLE -> FETCH -> EXEC -> WRITE and produces exactly one
//               registered write pulse (w/select_register/s) with done.
//               Optional macro REG_CTRL_SAT_EN (inside reg_ctrl_alu) selects
//               saturating ADD/SUB instead of modulo wrap.
// Ports       :
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   cmd               command handshake (slave modport)
//   r1..r4            register file contents, index 0..3
//   w                 register file write enable
//   select_register   register file write index
//   s                 register file write data
//   done              one-cycle pulse coincident with w
//   flag_c            carry/borrow of the last ADD/SUB
// Revision    : 1.0  initial release
//==============================================================================
module reg_ctrl_seq
   import reg_ctrl_pkg::*;
#(
   parameter int N = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   reg_ctrl_seq_if.slave        cmd,
   input  logic [N-1:0]         r1,
   input  logic [N-1:0]         r2,
   input  logic [N-1:0]         r3,
   input  logic [N-1:0]         r4,
   output logic                 w,
   output logic [1:0]           select_register,
   output logic [N-1:0]         s,
   output logic                 done,
   output logic                 flag_c
);

   // FSM state
   state_t        r_state;
   state_t        w_state_nxt;

   // Latched command
   op_t           r_op;
   logic [1:0]    r_dst;
   logic [1:0]    r_srca;
   logic [1:0]    r_srcb;
   logic [N-1:0]  r_imm;

   // Latched operands
   logic [N-1:0]  r_a;
   logic [N-1:0]  r_b;

   // Registered outputs
   logic          r_w;
   logic          r_done;
   logic [1:0]    r_sel;
   logic [N-1:0]  r_s;
   logic          r_flag_c;

   // Next-state / control
   logic          w_cmd_ready;
   logic          w_latch_cmd;
   logic          w_latch_ops;
   logic          w_w_nxt;
   logic          w_done_nxt;
   logic [1:0]    w_sel_nxt;
   logic [N-1:0]  w_s_nxt;
   logic          w_flag_c_nxt;

   // Datapath
   logic [N-1:0]  w_rd_a;
   logic [N-1:0]  w_rd_b;
   logic [N-1:0]  w_alu_res;
   logic          w_alu_carry;

   // Ready is forced low while reset is asserted so a command presented
   // in the reset cycle is never seen as accepted
   assign w_cmd_ready   = (r_state == ST_IDLE) & ~rst;
   assign cmd.cmd_ready = w_cmd_ready;

   //---------------------------------------------------------------------------
   // Register-bus read multiplexers
   //---------------------------------------------------------------------------
   always_comb begin
      w_rd_a = r1;
      case (r_srca)
         R1_IDX:  w_rd_a = r1;
         R2_IDX:  w_rd_a = r2;
         R3_IDX:  w_rd_a = r3;
         R4_IDX:  w_rd_a = r4;
         default: w_rd_a = r1;
      endcase
   end

   always_comb begin
      w_rd_b = r1;
      case (r_srcb)
         R1_IDX:  w_rd_b = r1;
         R2_IDX:  w_rd_b = r2;
         R3_IDX:  w_rd_b = r3;
         R4_IDX:  w_rd_b = r4;
         default: w_rd_b = r1;
      endcase
   end

   //---------------------------------------------------------------------------
   // Arithmetic
   //---------------------------------------------------------------------------
   reg_ctrl_alu #(
      .N      (N)
   ) u_alu (
      .op     (r_op),
      .a      (r_a),
      .b      (r_b),
      .imm    (r_imm),
      .result (w_alu_res),
      .carry  (w_alu_carry)
   );

   //---------------------------------------------------------------------------
   // FSM next-state and next-output logic
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_latch_cmd  = 1'b0;
      w_latch_ops  = 1'b0;
      w_w_nxt      = 1'b0;
      w_done_nxt   = 1'b0;
      w_sel_nxt    = r_sel;
      w_s_nxt      = r_s;
      w_flag_c_nxt = r_flag_c;

      case (r_state)
         ST_IDLE: begin
            if (cmd.cmd_valid && w_cmd_ready) begin
               w_latch_cmd = 1'b1;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            w_latch_ops = 1'b1;
            w_state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            // Result goes straight into the s flop; the write pulse is
            // armed on this same edge so it is high for the WRITE cycle
            w_w_nxt     = 1'b1;
            w_done_nxt  = 1'b1;
            w_sel_nxt   = r_dst;
            w_s_nxt     = w_alu_res;
            if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
               w_flag_c_nxt = w_alu_carry;
            end
            w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // State register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // Command / operand latches and registered outputs
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op     <= OP_MOV;
         r_dst    <= 2'd0;
         r_srca   <= 2'd0;
         r_srcb   <= 2'd0;
         r_imm    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_w      <= 1'b0;
         r_done   <= 1'b0;
         r_sel    <= 2'd0;
         r_s      <= '0;
         r_flag_c <= 1'b0;
      end else begin
         if (w_latch_cmd) begin
            r_op   <= op_t'(cmd.cmd_op);
            r_dst  <= cmd.cmd_dst;
            r_srca <= cmd.cmd_srca;
            r_srcb <= cmd.cmd_srcb;
            r_imm  <= cmd.cmd_imm;
         end
         if (w_latch_ops) begin
            r_a <= w_rd_a;
            r_b <= w_rd_b;
         end
         r_w      <= w_w_nxt;
         r_done   <= w_done_nxt;
         r_sel    <= w_sel_nxt;
         r_s      <= w_s_nxt;
         r_flag_c <= w_flag_c_nxt;
      end
   end

   assign w               = r_w;
   assign done            = r_done;
   assign select_register = r_sel;
   assign s               = r_s;
   assign flag_c          = r_flag_c;

endmodule : reg_ctrl_seq
`default_nettype wire

// File: tb/tb_reg_ctrl_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_reg_ctrl_seq
// Description : Self-checking bench for reg_ctrl_seq. Holds a 4-entry
//               register file model written by the sequencer, drives directed
//               commands through the interface and compares every output
//               against hand-computed values. Honours REG_CTRL_SAT_EN.
// Revision    : 1.0  initial release
//==============================================================================
module tb_reg_ctrl_seq;

   localparam int N = 16;

   localparam logic [1:0] OP_MOV = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_LDI = 2'b11;

`ifdef REG_CTRL_SAT_EN
   localparam logic [N-1:0] EXP_ADD_OVF = 16'hFFFF;
   localparam logic [N-1:0] EXP_SUB_UNF = 16'h0000;
`else
   localparam logic [N-1:0] EXP_ADD_OVF = 16'h0000;
   localparam logic [N-1:0] EXP_SUB_UNF = 16'hFFFF;
`endif

   logic          clk;
   logic          rst;
   logic          w;
   logic [1:0]    select_register;
   logic [N-1:0]  s;
   logic          done;
   logic          flag_c;
   logic [N-1:0]  rf [0:3];

   int            n_checks;
   int            n_fail;

   reg_ctrl_seq_if #(.N(N)) cmd_if ();

   reg_ctrl_seq #(
      .N               (N)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cmd             (cmd_if),
      .r1              (rf[0]),
      .r2              (rf[1]),
      .r3              (rf[2]),
      .r4              (rf[3]),
      .w               (w),
      .select_register (select_register),
      .s               (s),
      .done            (done),
      .flag_c          (flag_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model; reset contents are 2,1,0,0
   always @(posedge clk) begin
      if (rst) begin
         rf[0] <= 16'd2;
         rf[1] <= 16'd1;
         rf[2] <= 16'd0;
         rf[3] <= 16'd0;
      end else if (w) begin
         rf[select_register] <= s;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called at a negedge in an IDLE cycle; returns at the negedge of the
   // IDLE cycle following WRITE. Accept edge k, w high in cycle k+3.
   task automatic do_cmd(input string tag, input logic [1:0] op, input logic [1:0] dst,
                         input logic [1:0] a, input logic [1:0] b, input logic [N-1:0] imm,
                         input logic [N-1:0] exp_s, input logic exp_c, input bit hold);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_dst   = dst;
      cmd_if.cmd_srca  = a;
      cmd_if.cmd_srcb  = b;
      cmd_if.cmd_imm   = imm;
      #1;
      chk({tag, ".ready_idle"}, cmd_if.cmd_ready, 1);
      chk({tag, ".w_idle"}, w, 0);
      @(posedge clk);
      @(negedge clk);
      if (!hold) cmd_if.cmd_valid = 1'b0;
      chk({tag, ".ready_fetch"}, cmd_if.cmd_ready, 0);
      chk({tag, ".w_fetch"}, w, 0);
      @(negedge clk);
      chk({tag, ".ready_exec"}, cmd_if.cmd_ready, 0);
      chk({tag, ".w_exec"}, w, 0);
      @(negedge clk);
      chk({tag, ".w_write"}, w, 1);
      chk({tag, ".done"}, done, 1);
      chk({tag, ".sel"}, select_register, dst);
      chk({tag, ".s"}, s, exp_s);
      chk({tag, ".flag_c"}, flag_c, exp_c);
      chk({tag, ".ready_write"}, cmd_if.cmd_ready, 0);
      @(negedge clk);
      chk({tag, ".w_after"}, w, 0);
      chk({tag, ".done_after"}, done, 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = OP_MOV;
      cmd_if.cmd_dst   = 2'd0;
      cmd_if.cmd_srca  = 2'd0;
      cmd_if.cmd_srcb  = 2'd0;
      cmd_if.cmd_imm   = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst.ready", cmd_if.cmd_ready, 0);
      chk("rst.w", w, 0);
      chk("rst.sel", select_register, 0);
      chk("rst.s", s, 0);
      chk("rst.done", done, 0);
      chk("rst.flag_c", flag_c, 0);
      rst = 1'b0;
      #1;
      chk("rst.ready_release", cmd_if.cmd_ready, 1);

      // r = 2,1,0,0
      do_cmd("add_basic", OP_ADD, 2'd2, 2'd0, 2'd1, '0, 16'd3, 1'b0, 1'b0);
      do_cmd("ldi_ffff", OP_LDI, 2'd3, 2'd0, 2'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      do_cmd("add_ovf", OP_ADD, 2'd3, 2'd3, 2'd1, '0, EXP_ADD_OVF, 1'b1, 1'b0);
      do_cmd("sub_unf", OP_SUB, 2'd0, 2'd1, 2'd0, '0, EXP_SUB_UNF, 1'b1, 1'b0);
      // LDI leaves the borrow flag from SUB untouched
      do_cmd("ldi_keep_c", OP_LDI, 2'd2, 2'd0, 2'd0, 16'h1234, 16'h1234, 1'b1, 1'b0);

      // Reset asserted in the EXEC cycle of an ADD
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = OP_ADD;
      cmd_if.cmd_dst   = 2'd1;
      cmd_if.cmd_srca  = 2'd0;
      cmd_if.cmd_srcb  = 2'd0;
      @(posedge clk);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort.w", w, 0);
      chk("abort.done", done, 0);
      chk("abort.sel", select_register, 0);
      chk("abort.s", s, 0);
      chk("abort.flag_c", flag_c, 0);
      chk("abort.ready_in_rst", cmd_if.cmd_ready, 0);
      rst = 1'b0;
      #1;
      chk("abort.ready_release", cmd_if.cmd_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort.no_w", w, 0);
      end

      // Reset and cmd_valid together: command must be dropped
      rst = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = OP_LDI;
      cmd_if.cmd_dst   = 2'd3;
      cmd_if.cmd_imm   = 16'hABCD;
      #1;
      chk("rstwin.ready", cmd_if.cmd_ready, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rstwin.no_w", w, 0);
         chk("rstwin.ready", cmd_if.cmd_ready, 1);
      end

      // r = 2,1,0,0 again: self-overwrite then read-back
      do_cmd("add_self", OP_ADD, 2'd0, 2'd0, 2'd0, '0, 16'd4, 1'b0, 1'b0);
      do_cmd("mov_after_self", OP_MOV, 2'd1, 2'd0, 2'd0, '0, 16'd4, 1'b0, 1'b0);
      do_cmd("ldi_seed", OP_LDI, 2'd2, 2'd0, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b0);

      // r = 4,4,1234,0; cmd_valid held high through a chain of dependent MOVs
      do_cmd("b2b0", OP_MOV, 2'd3, 2'd2, 2'd0, '0, 16'h1234, 1'b0, 1'b1);
      do_cmd("b2b1", OP_MOV, 2'd0, 2'd3, 2'd0, '0, 16'h1234, 1'b0, 1'b1);
      do_cmd("b2b2", OP_MOV, 2'd1, 2'd0, 2'd0, '0, 16'h1234, 1'b0, 1'b1);
      do_cmd("b2b3", OP_MOV, 2'd2, 2'd1, 2'd0, '0, 16'h1234, 1'b0, 1'b1);
      cmd_if.cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("b2b.idle_w", w, 0);
         chk("b2b.idle_ready", cmd_if.cmd_ready, 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_reg_ctrl_seq
`default_nettype wire
